join_recv_arbiter: RTL and testbench

Round-robin arbiter that merges the `Channel` per-channel 64-bit AXI-Stream outputs of the multi-channel receive path into one AXI-Stream toward the DMA. It grants one channel at a time for a fixed-length burst, frames each burst with `m_axis_tlast`, and tags every beat with the source channel index. It sits between the per-channel receive FIFOs and the single DMA S2MM port.

---
 rtl/join_recv_arbiter.sv | 156 +++++++++++++++
 tb/tb_join_recv_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/join_recv_arbiter.sv
// join_recv_arbiter: round-robin merge of per-channel receive streams into one
// AXI-Stream toward the DMA. Each grant covers a fixed-length burst framed by
// m_axis_tlast; every beat is tagged with its source channel on m_axis_tid.
// Optional build macro JOIN_ARB_TIMEOUT_EN adds a stall timeout that releases a
// grant whose channel stops presenting data, plus the timeout pulse output.
//
// state | meaning
// IDLE  | scanning tvalid from rr_ptr for the next channel to grant
// BURST | granted channel muxed straight through until its tlast handshake
module join_recv_arbiter #(
  parameter int Channel    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 64
`ifdef JOIN_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 256
`endif
) (
  input  logic                          m_axis_aclk,
  input  logic                          m_axis_aresetn,
  input  logic [15:0]                   burst_len,
  input  logic [Channel-1:0]            s_axis_tvalid,
  output logic [Channel-1:0]            s_axis_tready,
  input  logic [Channel*DATA_WIDTH-1:0] s_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          busy
`ifdef JOIN_ARB_TIMEOUT_EN
  ,
  output logic                          timeout
`endif
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         len_q, len_d;
  logic                busy_q;
  logic                scan_hit;
  logic [ID_WIDTH-1:0] scan_idx;
  logic [ID_WIDTH-1:0] grant_next;
  logic                hs;

`ifdef JOIN_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;
  assign timeout = timeout_q;
`endif

  // Round-robin scan: first valid channel at or after rr_ptr, wrapping.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < Channel; i++) begin
      if (!scan_hit && s_axis_tvalid[(int'(rr_ptr_q) + i) % Channel]) begin
        scan_hit = 1'b1;
        scan_idx = ID_WIDTH'((int'(rr_ptr_q) + i) % Channel);
      end
    end
  end

  assign grant_next    = (grant_q == ID_WIDTH'(Channel - 1)) ? '0 : grant_q + 1'b1;
  assign m_axis_tdata  = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign m_axis_tid    = grant_q;
  assign m_axis_tvalid = (state_q == BURST) && s_axis_tvalid[grant_q];
  assign m_axis_tlast  = (state_q == BURST) && (cnt_q == len_q - 16'd1);
  assign hs            = m_axis_tvalid && m_axis_tready;
  assign busy          = busy_q;

  // Next-state logic and the ready fan-out back to the granted channel.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    s_axis_tready = '0;
`ifdef JOIN_ARB_TIMEOUT_EN
    stall_d       = '0;
    timeout_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (scan_hit) begin
          grant_d = scan_idx;
          len_d   = (burst_len == 16'd0) ? 16'd1 : burst_len;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        s_axis_tready[grant_q] = m_axis_tready;
        if (hs) begin
          cnt_d = cnt_q + 16'd1;
          if (m_axis_tlast) begin
            state_d  = IDLE;
            rr_ptr_d = grant_next;
            cnt_d    = '0;
          end
        end
`ifdef JOIN_ARB_TIMEOUT_EN
        if (!hs) begin
          stall_d = stall_q;
          if (!s_axis_tvalid[grant_q]) begin
            stall_d = stall_q + 1'b1;
            // Leaving on the cycle the counter would reach TIMEOUT.
            if (stall_q == STALL_W'(TIMEOUT - 1)) begin
              stall_d   = '0;
              state_d   = IDLE;
              rr_ptr_d  = grant_next;
              cnt_d     = '0;
              timeout_d = 1'b1;
            end
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset can land mid-burst and simply drops it.
  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      len_q    <= 16'd1;
      busy_q   <= 1'b0;
`ifdef JOIN_ARB_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      busy_q   <= (state_d == BURST);
`ifdef JOIN_ARB_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_join_recv_arbiter.sv
// Directed bench for join_recv_arbiter (default build, no timeout feature).
module tb_join_recv_arbiter;
  localparam int CH = 4;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [15:0]       burst_len;
  logic [CH-1:0]     s_tvalid;
  logic [CH-1:0]     s_tready;
  logic [CH*DW-1:0]  s_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tlast;
  logic [1:0]        m_tid;
  logic              busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int viol = 0;
  bit chg_len = 1'b0;
  int seq [CH];

  typedef struct {
    int          tid;
    logic [63:0] data;
    bit          last;
    int          edge_n;
  } beat_t;
  beat_t beats [$];

  join_recv_arbiter dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rst_n),
    .burst_len     (burst_len),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tid    (m_tid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source model: channel c presents {c, running beat number} and advances on its handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) seq[i] <= 0;
    end else begin
      for (int i = 0; i < CH; i++)
        if (s_tready[i] && s_tvalid[i]) seq[i] <= seq[i] + 1;
    end
  end

  always_comb begin
    s_tdata = '0;
    for (int i = 0; i < CH; i++)
      s_tdata[i*DW +: DW] = (64'(i) << 32) | 64'(seq[i]);
  end

  // Monitor on the falling edge: log transfers, flag protocol violations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_tvalid && m_tready)
        beats.push_back('{int'(m_tid), m_tdata, m_tlast, cyc + 1});
      if (!busy && (s_tready != '0 || m_tvalid || m_tlast)) viol++;
      if ((s_tready & ~(4'b0001 << m_tid)) != '0) viol++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_tvalid = '0;
    m_tready = 1'b0;
    burst_len = 16'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    beats.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_beats(input int n, input bit toggle, input string tag);
    int b;
    b = 0;
    while (beats.size() < n && b < 500) begin
      @(posedge clk); #1;
      b++;
      if (toggle) m_tready = ~m_tready;
      if (chg_len && beats.size() >= 1) burst_len = 16'd6;
    end
    s_tvalid = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, " beats"}, 64'(beats.size()), 64'(n));
    check({tag, " busy end"}, busy, 1'b0);
  endtask

  task automatic check_seq(input string tag, input int order[8], input int nb, input int L,
                           input int first_edge, input bit gaps);
    int kc [CH];
    int c;
    int pos;
    for (int i = 0; i < CH; i++) kc[i] = 0;
    for (int j = 0; j < nb && j < beats.size(); j++) begin
      c = order[j / L];
      pos = j % L;
      check($sformatf("%s tid%0d", tag, j), 64'(beats[j].tid), 64'(c));
      check($sformatf("%s last%0d", tag, j), beats[j].last, pos == L - 1);
      check($sformatf("%s data%0d", tag, j), beats[j].data, (64'(c) << 32) | 64'(kc[c]));
      kc[c]++;
      if (gaps) begin
        if (j == 0)
          check($sformatf("%s edge0", tag), 64'(beats[0].edge_n), 64'(first_edge));
        else
          check($sformatf("%s gap%0d", tag, j), 64'(beats[j].edge_n - beats[j-1].edge_n),
                (pos == 0) ? 64'd2 : 64'd1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int e0;
    rst_n = 1'b0;
    s_tvalid = '0;
    m_tready = 1'b0;
    burst_len = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst tvalid", m_tvalid, 1'b0);
    check("rst tlast", m_tlast, 1'b0);
    check("rst tready", s_tready, 4'b0000);
    check("rst busy", busy, 1'b0);
    check("rst tid", m_tid, 2'd0);

    // Single channel, burst of 4, first beat two cycles after tvalid.
    do_reset();
    burst_len = 16'd4;
    m_tready = 1'b1;
    s_tvalid = 4'b0001;
    e0 = cyc;
    check("t1 idle tvalid", m_tvalid, 1'b0);
    @(posedge clk); #1;
    check("t1 busy", busy, 1'b1);
    run_beats(4, 1'b0, "t1");
    check_seq("t1", '{0, 0, 0, 0, 0, 0, 0, 0}, 4, 4, e0 + 2, 1'b1);

    // All channels valid, burst of 2: grants 0,1,2,3,0 with one bubble between bursts.
    do_reset();
    burst_len = 16'd2;
    m_tready = 1'b1;
    s_tvalid = 4'b1111;
    e0 = cyc;
    run_beats(10, 1'b0, "t2");
    check_seq("t2", '{0, 1, 2, 3, 0, 0, 0, 0}, 10, 2, e0 + 2, 1'b1);

    // Downstream ready toggling every cycle during a burst of 8.
    do_reset();
    burst_len = 16'd8;
    m_tready = 1'b1;
    s_tvalid = 4'b1111;
    run_beats(8, 1'b1, "t3");
    check_seq("t3", '{0, 0, 0, 0, 0, 0, 0, 0}, 8, 8, 0, 1'b0);

    // burst_len of 0 behaves as single-beat bursts.
    do_reset();
    burst_len = 16'd0;
    m_tready = 1'b1;
    s_tvalid = 4'b0010;
    e0 = cyc;
    run_beats(3, 1'b0, "t4a");
    check_seq("t4a", '{1, 1, 1, 0, 0, 0, 0, 0}, 3, 1, e0 + 2, 1'b1);

    // burst_len raised mid-burst must not stretch the current burst.
    do_reset();
    burst_len = 16'd4;
    m_tready = 1'b1;
    s_tvalid = 4'b1000;
    e0 = cyc;
    chg_len = 1'b1;
    run_beats(4, 1'b0, "t4b");
    chg_len = 1'b0;
    check_seq("t4b", '{3, 0, 0, 0, 0, 0, 0, 0}, 4, 4, e0 + 2, 1'b1);

    // Reset mid-burst, then round-robin restarts at channel 0.
    do_reset();
    burst_len = 16'd8;
    m_tready = 1'b1;
    s_tvalid = 4'b0100;
    for (int b = 0; b < 50 && beats.size() < 2; b++) begin
      @(posedge clk); #1;
    end
    check("t5 pre beats", 64'(beats.size()), 64'd2);
    rst_n = 1'b0;
    #1;
    check("t5 tvalid", m_tvalid, 1'b0);
    check("t5 tlast", m_tlast, 1'b0);
    check("t5 tready", s_tready, 4'b0000);
    check("t5 busy", busy, 1'b0);
    check("t5 tid", m_tid, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    beats.delete();
    burst_len = 16'd2;
    s_tvalid = 4'b1111;
    e0 = cyc;
    run_beats(2, 1'b0, "t5");
    check_seq("t5", '{0, 0, 0, 0, 0, 0, 0, 0}, 2, 2, e0 + 2, 1'b1);

    check("protocol viol", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
